// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg
// Shared definitions for the register-interface round-robin arbiter:
//   - arb_state_e   : controller states (IDLE / BUSY / ERR)
//   - reg_arb_req_t : register request  (valid, addr, write, wdata, wstrb)
//   - reg_arb_rsp_t : register response (ready, rdata, error)
//   - idx_width()   : index width for N requesters, never below 1 bit
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_arb_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_arb_rsp_t;

  // A single requester still needs a 1-bit index so that ports keep a legal width.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_arb_rr_sel.sv
// reg_arb_rr_sel
// Combinational round-robin picker. Scans valid[rr_ptr], valid[rr_ptr+1], ...
// (modulo NumReq) and reports the first set position.
// Ports:
//   valid  : one request-valid bit per requester
//   rr_ptr : index where the scan starts (highest priority this round)
//   found  : at least one valid bit is set
//   index  : winning requester index (0 when nothing is found)
module reg_arb_rr_sel
  import reg_arb_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  localparam int unsigned IdxW  = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   rr_ptr,
  output logic              found,
  output logic [IdxW-1:0]   index
);

  // Walk the requesters starting at rr_ptr; the first hit wins and later
  // candidates are ignored through the found flag.
  always_comb begin
    logic [IdxW-1:0] cand;
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand = IdxW'((32'(rr_ptr) + off) % NumReq);
      if (!found && valid[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/reg_rr_arbiter.sv
// reg_rr_arbiter
// Round-robin arbiter sharing one register-interface target among NumReq
// requesters, with an optional watchdog that aborts a hung transfer.
// Ports:
//   clk_i     : clock, all state on the rising edge
//   rst_i     : asynchronous active-high reset
//   req_i     : per-requester register requests
//   rsp_o     : per-requester register responses
//   req_o     : request forwarded to the shared target
//   rsp_i     : response from the shared target
//   gnt_o     : index of the latched grant
//   busy_o    : high while a transfer is in flight (BUSY or ERR)
//   timeout_o : one-cycle pulse when the watchdog aborts a transfer
// The request/response type parameters default to the package structs; a bare
// logic default could not carry the valid/ready/... fields the arbiter reads.
module reg_rr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 0,
  parameter type         reg_req_t     = reg_arb_req_t,
  parameter type         reg_rsp_t     = reg_arb_rsp_t,
  localparam int unsigned GntW         = idx_width(NumReq)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  reg_req_t [NumReq-1:0] req_i,
  output reg_rsp_t [NumReq-1:0] rsp_o,
  output reg_req_t              req_o,
  input  reg_rsp_t              rsp_i,
  output logic [GntW-1:0]       gnt_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  // Counter is sized to hold TimeoutCycles and is kept at least 1 bit wide
  // so the disabled configuration still elaborates.
  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;
  localparam logic [GntW-1:0] LastIdx = GntW'(NumReq - 1);

  arb_state_e      state_q, state_d;
  logic [GntW-1:0] gnt_q, gnt_d;
  logic [GntW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NumReq-1:0] valid_vec;
  logic              sel_found;
  logic [GntW-1:0]   sel_index;

  function automatic logic [GntW-1:0] advance(input logic [GntW-1:0] g);
    return (g == LastIdx) ? '0 : g + GntW'(1);
  endfunction

  // Gather the valid bits so the picker stays independent of the struct type.
  always_comb begin
    valid_vec = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      valid_vec[k] = req_i[k].valid;
    end
  end

  reg_arb_rr_sel #(
    .NumReq (NumReq)
  ) u_rr_sel (
    .valid  (valid_vec),
    .rr_ptr (rr_ptr_q),
    .found  (sel_found),
    .index  (sel_index)
  );

  // State register: reset aborts any transfer without a response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and output logic. A requester dropping valid mid-transfer
  // takes priority over everything, then target ready, then the watchdog,
  // so a ready arriving on the last allowed cycle still completes normally.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    req_o     = '0;
    rsp_o     = '0;
    timeout_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          gnt_d   = sel_index;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        req_o        = req_i[gnt_q];
        rsp_o[gnt_q] = rsp_i;
        if (!req_i[gnt_q].valid) begin
          state_d = IDLE;
        end else if (rsp_i.ready) begin
          rr_ptr_d = advance(gnt_q);
          state_d  = IDLE;
        end else if (TimeoutCycles > 0) begin
          if (cnt_q == CntLast) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      ERR: begin
        rsp_o[gnt_q].ready = 1'b1;
        rsp_o[gnt_q].error = 1'b1;
        timeout_o          = 1'b1;
        rr_ptr_d           = advance(gnt_q);
        state_d            = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt_o  = gnt_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// tb_reg_rr_arbiter
// Directed bench for reg_rr_arbiter with three requesters and an 8-cycle
// watchdog. A behavioural model tracks who owns the target and how long it
// has waited; a compare process checks every DUT output against it on each
// falling edge, and the directed scenarios add literal expectations.
module tb_reg_rr_arbiter;
  import reg_arb_pkg::*;

  localparam int N = 3;
  localparam int T = 8;

  logic               clk;
  logic               rst;
  reg_arb_req_t [N-1:0] req_i;
  reg_arb_rsp_t [N-1:0] rsp_o;
  reg_arb_req_t       req_o;
  reg_arb_rsp_t       rsp_i;
  logic [1:0]         gnt_o;
  logic               busy_o;
  logic               timeout_o;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Model state: current owner (-1 when nobody), cycles waited, error pending.
  int m_owner  = -1;
  int m_waited = 0;
  int m_ptr    = 0;
  int m_gnt    = 0;
  bit m_erring = 1'b0;

  reg_rr_arbiter #(
    .NumReq        (N),
    .TimeoutCycles (T),
    .reg_req_t     (reg_arb_req_t),
    .reg_rsp_t     (reg_arb_rsp_t)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req_i),
    .rsp_o     (rsp_o),
    .req_o     (req_o),
    .rsp_i     (rsp_i),
    .gnt_o     (gnt_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input int k, input bit valid, input bit write,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_i[k].valid = valid;
    req_i[k].write = write;
    req_i[k].addr  = addr;
    req_i[k].wdata = wdata;
    req_i[k].wstrb = 4'hF;
  endtask

  task automatic setTarget(input bit ready, input logic [31:0] rdata);
    rsp_i.ready = ready;
    rsp_i.rdata = rdata;
    rsp_i.error = 1'b0;
  endtask

  task automatic clearInputs();
    req_i = '0;
    rsp_i = '0;
  endtask

  // Model update: one transfer owner at a time, fair rotation after each
  // finished or aborted transfer, error after T unanswered cycles.
  task automatic modelStep();
    bit hit;
    if (rst) begin
      m_owner = -1; m_waited = 0; m_ptr = 0; m_gnt = 0; m_erring = 1'b0;
    end else if (m_erring) begin
      m_erring = 1'b0;
      m_ptr    = (m_owner + 1) % N;
      m_owner  = -1;
    end else if (m_owner >= 0) begin
      if (!req_i[m_owner].valid) begin
        m_owner = -1;
      end else if (rsp_i.ready) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_waited++;
        if (m_waited == T) m_erring = 1'b1;
      end
    end else begin
      hit = 1'b0;
      for (int off = 0; off < N; off++) begin
        if (!hit && req_i[(m_ptr + off) % N].valid) begin
          hit      = 1'b1;
          m_owner  = (m_ptr + off) % N;
          m_gnt    = m_owner;
          m_waited = 0;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      modelStep();
    end
  end

  // Every falling edge: derive the expected outputs from the model and compare.
  initial begin
    reg_arb_req_t         e_req;
    reg_arb_rsp_t [N-1:0] e_rsp;
    bit                   e_busy, e_to;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        e_req  = '0;
        e_rsp  = '0;
        e_busy = 1'b0;
        e_to   = 1'b0;
        if (m_owner >= 0) begin
          e_busy = 1'b1;
          if (m_erring) begin
            e_rsp[m_owner].ready = 1'b1;
            e_rsp[m_owner].error = 1'b1;
            e_to = 1'b1;
          end else begin
            e_req          = req_i[m_owner];
            e_rsp[m_owner] = rsp_i;
          end
        end
        checkOutput("model_req_o", 128'(req_o), 128'(e_req));
        checkOutput("model_rsp_o", 128'(rsp_o), 128'(e_rsp));
        checkOutput("model_gnt_o", 128'(gnt_o), 128'(m_gnt));
        checkOutput("model_busy_o", 128'(busy_o), 128'(e_busy));
        checkOutput("model_timeout_o", 128'(timeout_o), 128'(e_to));
      end
    end
  end

  task automatic applyReset();
    @(posedge clk); #1;
    rst = 1'b1;
    clearInputs();
    @(negedge clk);
    checkOutput("reset_busy", 128'(busy_o), 128'(0));
    checkOutput("reset_req_o", 128'(req_o), 128'(0));
    checkOutput("reset_rsp_o", 128'(rsp_o), 128'(0));
    checkOutput("reset_gnt", 128'(gnt_o), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int grants[$];
    int seen_valid;
    bit hit;

    rst = 1'b0;
    clearInputs();
    #2 rst = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("por_busy", 128'(busy_o), 128'(0));
    checkOutput("por_timeout", 128'(timeout_o), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write from requester 1, target ready at once.
    $display("[TB] single transfer");
    applyStimulus(1, 1'b1, 1'b1, 32'h10, 32'hA5A5A5A5);
    setTarget(1'b1, 32'h0);
    @(negedge clk);
    checkOutput("single_idle_valid", 128'(req_o.valid), 128'(0));
    @(negedge clk);
    checkOutput("single_addr", 128'(req_o.addr), 128'(32'h10));
    checkOutput("single_wdata", 128'(req_o.wdata), 128'(32'hA5A5A5A5));
    checkOutput("single_ready1", 128'(rsp_o[1].ready), 128'(1));
    checkOutput("single_gnt", 128'(gnt_o), 128'(1));
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(2, 1'b1, 1'b0, 32'h4, 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ptr_after_single", 128'(gnt_o), 128'(2));

    // Fairness: everyone requests, target always ready.
    applyReset();
    $display("[TB] fairness");
    for (int k = 0; k < N; k++) applyStimulus(k, 1'b1, 1'b0, 32'(k * 4), 32'h0);
    setTarget(1'b1, 32'h0000_1234);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy_o) grants.push_back(int'(gnt_o));
    end
    checkOutput("fair_count", 128'(grants.size()), 128'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < grants.size()) checkOutput("fair_order", 128'(grants[i]), 128'(i % 3));
      else checkOutput("fair_order_missing", 128'(1), 128'(0));
    end

    // Watchdog: requester 2 reads, target never answers.
    applyReset();
    $display("[TB] timeout");
    applyStimulus(2, 1'b1, 1'b0, 32'h20, 32'h0);
    setTarget(1'b0, 32'h1234_5678);
    seen_valid = 0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (timeout_o) begin
        hit = 1'b1;
        checkOutput("to_ready", 128'(rsp_o[2].ready), 128'(1));
        checkOutput("to_error", 128'(rsp_o[2].error), 128'(1));
        checkOutput("to_rdata", 128'(rsp_o[2].rdata), 128'(0));
        checkOutput("to_req_valid", 128'(req_o.valid), 128'(0));
      end else if (req_o.valid) begin
        seen_valid++;
      end
    end
    checkOutput("to_reached", 128'(hit), 128'(1));
    checkOutput("to_valid_cycles", 128'(seen_valid), 128'(8));
    @(negedge clk);
    checkOutput("to_busy_after", 128'(busy_o), 128'(0));
    checkOutput("to_pulse_width", 128'(timeout_o), 128'(0));

    // Race: ready lands on the last allowed BUSY cycle.
    applyReset();
    $display("[TB] ready vs timeout race");
    applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'h0);
    setTarget(1'b0, 32'hDEADBEEF);
    repeat (8) @(posedge clk);
    #1 rsp_i.ready = 1'b1;
    @(negedge clk);
    checkOutput("race_ready", 128'(rsp_o[0].ready), 128'(1));
    checkOutput("race_rdata", 128'(rsp_o[0].rdata), 128'(32'hDEADBEEF));
    checkOutput("race_error", 128'(rsp_o[0].error), 128'(0));
    checkOutput("race_timeout", 128'(timeout_o), 128'(0));
    @(posedge clk); #1;
    clearInputs();
    @(negedge clk);
    checkOutput("race_timeout_next", 128'(timeout_o), 128'(0));
    checkOutput("race_busy_next", 128'(busy_o), 128'(0));

    // Reset in the third BUSY cycle of a transfer from requester 1.
    applyReset();
    $display("[TB] reset mid-transfer");
    applyStimulus(1, 1'b1, 1'b1, 32'h40, 32'h1);
    setTarget(1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_mid_valid", 128'(req_o.valid), 128'(0));
    checkOutput("rst_mid_ready", 128'({rsp_o[2].ready, rsp_o[1].ready, rsp_o[0].ready}), 128'(0));
    checkOutput("rst_mid_busy", 128'(busy_o), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) applyStimulus(k, 1'b1, 1'b0, 32'h50, 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid_next_gnt", 128'(gnt_o), 128'(0));

    // Drop: requester 1 withdraws before the target answers.
    applyReset();
    $display("[TB] requester drop");
    applyStimulus(0, 1'b1, 1'b0, 32'h60, 32'h0);
    setTarget(1'b1, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h64, 32'h0);
    setTarget(1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 req_i[1].valid = 1'b0;
    @(negedge clk);
    checkOutput("drop_gnt", 128'(gnt_o), 128'(1));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("drop_busy", 128'(busy_o), 128'(0));
    checkOutput("drop_no_rsp", 128'(rsp_o[1].ready), 128'(0));
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) applyStimulus(k, 1'b1, 1'b0, 32'h70, 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("drop_ptr_kept", 128'(gnt_o), 128'(1));

    applyReset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_rr_arbiter.md
REG_RR_ARBITER -- requirements
Module: reg_rr_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requester ports (>=1).
REQ-002 SHALL have parameter TimeoutCycles, default 0, target watchdog limit in cycles (0 = disabled).
REQ-003 SHALL have parameters reg_req_t and reg_rsp_t, default logic, register-interface request/response structs (valid,addr,write,wdata,wstrb / ready,rdata,error).
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_i  input  NumReq x reg_req_t  requester requests.
REQ-007 SHALL have port rsp_o  output  NumReq x reg_rsp_t  requester responses.
REQ-008 SHALL have port req_o  output  reg_req_t  shared target request.
REQ-009 SHALL have port rsp_i  input  reg_rsp_t  shared target response.
REQ-010 SHALL have port gnt_o  output  $clog2(NumReq) (min 1)  index of current grant.
REQ-011 SHALL have port busy_o  output  1  high while in BUSY or ERR.
REQ-012 SHALL have port timeout_o  output  1  one-cycle pulse on watchdog abort.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, ERR.
REQ-014 In IDLE, if any req_i[k].valid, SHALL grant the first valid index found scanning rr_ptr, rr_ptr+1, ... modulo NumReq, latch it into gnt, clear the watchdog counter, and go to BUSY next cycle.
REQ-015 In IDLE, req_o.valid SHALL be 0 and every rsp_o[k].ready SHALL be 0.
REQ-016 In BUSY, req_o SHALL equal req_i[gnt] combinationally and rsp_o[gnt] SHALL equal rsp_i combinationally; all other rsp_o SHALL be all-zero.
REQ-017 In BUSY, rsp_i.ready=1 SHALL complete the transfer: rr_ptr <= (gnt+1) mod NumReq, next state IDLE.
REQ-018 Minimum latency: valid seen in IDLE at cycle t -> req_o.valid at t+1; ready at t+1 -> requester sees ready at t+1; next grant earliest at t+2.
REQ-019 In BUSY, if req_i[gnt].valid drops before ready (protocol violation), SHALL return to IDLE without response and without advancing rr_ptr.
REQ-020 With TimeoutCycles>0, the counter SHALL increment each BUSY cycle without ready; when it equals TimeoutCycles-1 and ready=0, next state SHALL be ERR.
REQ-021 Ready arriving in the cycle the counter equals TimeoutCycles-1 SHALL complete normally (ready wins over timeout).
REQ-022 In ERR (exactly one cycle), req_o.valid SHALL be 0, rsp_o[gnt] SHALL be ready=1, error=1, rdata=0, timeout_o=1, rr_ptr SHALL advance as in REQ-017, next state IDLE.
REQ-023 Counter width SHALL be $clog2(TimeoutCycles+1) and SHALL never wrap.
REQ-024 gnt_o SHALL reflect latched gnt in all states; NumReq=1 SHALL work with gnt fixed at 0.

Reset
REQ-025 rst_i SHALL asynchronously force state IDLE, rr_ptr=0, gnt=0, counter=0.
REQ-026 During/after reset, req_o SHALL be all-zero, all rsp_o all-zero, busy_o=0, timeout_o=0.
REQ-027 Reset asserted mid-transfer SHALL abort it silently; no response to the aborted requester.

Structure
REQ-028 State enum (IDLE/BUSY/ERR) SHALL live in shared package reg_arb_pkg.
REQ-029 Round-robin selection SHALL be a combinational sub-module reg_arb_rr_sel (inputs valid vector, rr_ptr; outputs found, index).
REQ-030 Implementation SHALL be 120-400 lines, no latches.

Verification (NumReq=3, TimeoutCycles=8)
REQ-031 Single: req_i[1] write addr 0x10 wdata 0xA5A5A5A5, target ready same cycle -> req_o.addr=0x10 at t+1, rsp_o[1].ready=1 at t+1, gnt_o=1, rr_ptr=2.
REQ-032 Fairness: all three valid continuously, target always ready -> grant order 0,1,2,0,1,2, one grant per 2 cycles.
REQ-033 Timeout: req_i[2] read, target never ready -> req_o.valid for 8 cycles, then rsp_o[2].ready=1 error=1 rdata=0, timeout_o pulse, busy_o low next cycle.
REQ-034 Race: target ready in 8th BUSY cycle -> normal completion, timeout_o stays 0, rdata passed.
REQ-035 Reset mid-op: rst_i pulsed in 3rd BUSY cycle -> req_o.valid=0 immediately, no rsp_o ready, next grant starts at index 0.
REQ-036 Drop: req_i[0].valid deasserted in BUSY before ready -> IDLE next cycle, no response, rr_ptr unchanged.
